gshare_pht: RTL and testbench
=============================

GSHARE_PHT -- requirements
Module: gshare_pht

Interface
REQ-001 Parameter PHT_ROWS, default 8: number of counter entries; power of two, at least 2.
REQ-002 Parameter CTR_BITS, default 2: saturating counter width, 1 to 4.
REQ-003 Parameter GHR_BITS, default 3: global history length, 0 to IDX_BITS, where IDX_BITS = log2(PHT_ROWS).
REQ-004 Port list:
- clock  in  1  system clock; one clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  gates all state updates.
- pred_valid  in  1  fetch lookup request.
- pred_pc  in  32  fetch PC.
- prediction  out  1  taken prediction.
- pred_idx  out  IDX_BITS  table index used by the lookup.
- pred_ghr  out  GHR_BITS  GHR checkpoint before this lookup's shift.
- upd_valid  in  1  resolved-branch update.
- upd_idx  in  IDX_BITS  index returned from the lookup.
- upd_taken  in  1  actual outcome.
- upd_mispredict  in  1  history recovery request.
- upd_ghr  in  GHR_BITS  checkpoint returned from the lookup.
- ghr_out  out  GHR_BITS  current global history.

Function
REQ-005 pred_idx SHALL be pred_pc[2 +: IDX_BITS] XOR the zero-extended GHR, combinationally.
REQ-006 prediction SHALL be the MSB of counter[pred_idx], combinationally, from pre-edge state.
REQ-007 pred_ghr SHALL equal the current GHR, combinationally.
REQ-008 On a posedge with enable && upd_valid, counter[upd_idx] SHALL move by one step: +1 if upd_taken, else -1.
REQ-009 Counter updates SHALL saturate at 0 and at 2^CTR_BITS-1; there is no wrap-around.
REQ-010 On a posedge with enable && pred_valid && !(upd_valid && upd_mispredict), the GHR SHALL become {GHR[GHR_BITS-2:0], prediction}.
REQ-011 On a posedge with enable && upd_valid && upd_mispredict, the GHR SHALL become {upd_ghr[GHR_BITS-2:0], upd_taken}; recovery overrides a same-cycle speculative shift.
REQ-012 When a lookup and an update hit the same index in one cycle, the lookup SHALL see the old counter (no bypass); the write SHALL still take effect.
REQ-013 With enable low, all state SHALL hold; combinational outputs SHALL remain valid.
REQ-014 With GHR_BITS = 0, the GHR logic SHALL vanish, giving pure PC indexing; ghr_out and pred_ghr are then unused.
REQ-015 Prediction latency: 0 cycles. Update visibility: the cycle after the update edge.

Reset
REQ-016 Reset SHALL clear every counter to 0 (strongly not-taken) and clear the GHR to 0, asynchronously.
REQ-017 While reset is held, prediction SHALL be 0 and ghr_out SHALL be 0.
REQ-018 Reset asserted mid-operation SHALL discard pending same-cycle updates.

Configuration
REQ-019 Macro PHT_DEBUG_EN defined: the block SHALL add output pht_out[PHT_ROWS-1:0][CTR_BITS-1:0], mirroring all counters.
REQ-020 PHT_DEBUG_EN undefined: pht_out SHALL be absent; behaviour is otherwise identical.

Structure
REQ-021 A shared package bp_pkg SHALL hold the default constants (PHT_ROWS_DEF, CTR_BITS_DEF, GHR_BITS_DEF) and the counter step function sat_ctr_next(ctr, taken).
REQ-022 A sub-module ghr_reg SHALL hold the GHR with its shift and recover logic; the counter array SHALL stay in gshare_pht.

Verification (PHT_ROWS=8, CTR_BITS=2, GHR_BITS=3)
REQ-023 Reset, then 3 taken updates to idx 5 -> counter 1, 2, 3 in turn; prediction flips to 1 after the 2nd update; a 4th update stays at 3.
REQ-024 Counter 5 at 0 and not-taken update -> stays 0 (saturation floor).
REQ-025 GHR=3'b000, pred_valid with prediction 1 on 3 consecutive cycles -> ghr_out 001, 011, 111; pred_pc=0x14 with GHR 111 gives pred_idx 5^7 = 2.
REQ-026 Same cycle: pred_valid with prediction 1, plus upd_mispredict with upd_ghr=3'b010, upd_taken=0 -> ghr_out = 3'b100 (recovery wins).
REQ-027 Same-cycle lookup and update at idx 4 (counter 1, taken) -> prediction 0 that cycle, 1 the next.
REQ-028 enable=0 with upd_valid, pred_valid and upd_mispredict asserted -> pht_out and ghr_out unchanged; assert reset mid-sequence -> all counters and GHR become 0 immediately.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor constants and the saturating counter step.
package bp_pkg;

    localparam int PHT_ROWS_DEF = 8;
    localparam int CTR_BITS_DEF = 2;
    localparam int GHR_BITS_DEF = 3;
    localparam int CTR_BITS_MAX = 4;

    // One up/down step of a ctr_bits-wide counter, pinned at 0 and at all-ones.
    function automatic logic [CTR_BITS_MAX-1:0] sat_ctr_next(
        input logic [CTR_BITS_MAX-1:0] ctr,
        input logic                    taken,
        input int                      ctr_bits
    );
        logic [CTR_BITS_MAX-1:0] ctr_max;
        logic [CTR_BITS_MAX-1:0] result;
        ctr_max = CTR_BITS_MAX'((1 << ctr_bits) - 1);
        result  = ctr;
        if (taken) begin
            if (ctr != ctr_max) result = ctr + 1'b1;
        end else begin
            if (ctr != '0) result = ctr - 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ghr_reg.sv
// Global history register: speculative shift on lookup, checkpoint restore on mispredict.
module ghr_reg #(
    parameter int GHR_BITS = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                shift_valid,
    input  logic                shift_bit,
    input  logic                recover_valid,
    input  logic                recover_bit,
    input  logic [GHR_BITS-1:0] recover_ghr,
    output logic [GHR_BITS-1:0] ghr
);

    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] shift_next;
    logic [GHR_BITS-1:0] recover_next;

    generate
        if (GHR_BITS == 1) begin : g_one_bit
            logic unused_recover;
            assign shift_next     = shift_bit;
            assign recover_next   = recover_bit;
            assign unused_recover = ^recover_ghr;
        end else begin : g_multi_bit
            logic unused_recover_msb;
            assign shift_next         = {ghr_q[GHR_BITS-2:0], shift_bit};
            assign recover_next       = {recover_ghr[GHR_BITS-2:0], recover_bit};
            assign unused_recover_msb = recover_ghr[GHR_BITS-1];
        end
    endgenerate

    // Recovery takes priority so a wrong-path lookup in the same cycle is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
        end else if (enable) begin
            if (recover_valid) begin
                ghr_q <= recover_next;
            end else if (shift_valid) begin
                ghr_q <= shift_next;
            end
        end
    end

    assign ghr = ghr_q;

endmodule

// File: rtl/gshare_pht.sv
// Gshare pattern history table: PC xor global history indexes saturating counters.
// Define PHT_DEBUG_EN to expose every counter on pht_out.
module gshare_pht
    import bp_pkg::*;
#(
    parameter  int PHT_ROWS = PHT_ROWS_DEF,
    parameter  int CTR_BITS = CTR_BITS_DEF,
    parameter  int GHR_BITS = GHR_BITS_DEF,
    localparam int IDX_BITS = $clog2(PHT_ROWS),
    localparam int GHR_W    = (GHR_BITS > 0) ? GHR_BITS : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                pred_valid,
    input  logic [31:0]         pred_pc,
    output logic                prediction,
    output logic [IDX_BITS-1:0] pred_idx,
    output logic [GHR_W-1:0]    pred_ghr,
    input  logic                upd_valid,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken,
    input  logic                upd_mispredict,
    input  logic [GHR_W-1:0]    upd_ghr,
    output logic [GHR_W-1:0]    ghr_out
`ifdef PHT_DEBUG_EN
    ,
    output logic [PHT_ROWS-1:0][CTR_BITS-1:0] pht_out
`endif
);

    logic [PHT_ROWS-1:0][CTR_BITS-1:0] pht_q;
    logic [GHR_W-1:0]                  ghr;
    logic [IDX_BITS-1:0]               ghr_ext;
    logic                              unused_pc;

    generate
        if (GHR_BITS > 0) begin : g_ghr
            ghr_reg #(
                .GHR_BITS (GHR_BITS)
            ) u_ghr (
                .clock         (clock),
                .reset         (reset),
                .enable        (enable),
                .shift_valid   (pred_valid),
                .shift_bit     (prediction),
                .recover_valid (upd_valid && upd_mispredict),
                .recover_bit   (upd_taken),
                .recover_ghr   (upd_ghr),
                .ghr           (ghr)
            );
            assign ghr_ext = IDX_BITS'(ghr);
        end else begin : g_no_ghr
            // Pure PC indexing: history inputs are accepted but ignored.
            logic unused_hist;
            assign ghr         = '0;
            assign ghr_ext     = '0;
            assign unused_hist = ^{upd_ghr, upd_mispredict, pred_valid};
        end
    endgenerate

    assign pred_idx   = pred_pc[2 +: IDX_BITS] ^ ghr_ext;
    assign prediction = pht_q[pred_idx][CTR_BITS-1];
    assign pred_ghr   = ghr;
    assign ghr_out    = ghr;
    assign unused_pc  = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0]};

    // Lookups read pre-edge state, so a same-index update is seen only next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pht_q <= '0;
        end else if (enable && upd_valid) begin
            pht_q[upd_idx] <= CTR_BITS'(sat_ctr_next(CTR_BITS_MAX'(pht_q[upd_idx]),
                                                     upd_taken, CTR_BITS));
        end
    end

`ifdef PHT_DEBUG_EN
    assign pht_out = pht_q;
`else
    // Counters stay internal in the default build.
`endif

endmodule

// File: tb/tb_gshare_pht.sv
// Randomized self-checking bench for gshare_pht against an arithmetic reference model.
module tb_gshare_pht;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        prediction;
    logic [2:0]  pred_idx;
    logic [2:0]  pred_ghr;
    logic        upd_valid;
    logic [2:0]  upd_idx;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [2:0]  upd_ghr;
    logic [2:0]  ghr_out;
`ifdef PHT_DEBUG_EN
    logic [7:0][1:0] pht_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain integer counters and history.
    int m_ctr[8];
    int m_ghr;

    gshare_pht #(
        .PHT_ROWS (8),
        .CTR_BITS (2),
        .GHR_BITS (3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .prediction     (prediction),
        .pred_idx       (pred_idx),
        .pred_ghr       (pred_ghr),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .upd_ghr        (upd_ghr),
        .ghr_out        (ghr_out)
`ifdef PHT_DEBUG_EN
        ,
        .pht_out        (pht_out)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_ctr[i] = 0;
        m_ghr = 0;
    endtask

    // One clock cycle: drive at posedge+1, check outputs before the edge, advance model.
    task automatic step(input logic en, input logic pv, input logic [31:0] pc,
                        input logic uv, input logic [2:0] ui, input logic ut,
                        input logic um, input logic [2:0] ug);
        int idx;
        int p;
        enable         = en;
        pred_valid     = pv;
        pred_pc        = pc;
        upd_valid      = uv;
        upd_idx        = ui;
        upd_taken      = ut;
        upd_mispredict = um;
        upd_ghr        = ug;
        #3;
        idx = int'((pc >> 2) & 32'd7) ^ m_ghr;
        p   = (m_ctr[idx] >= 2) ? 1 : 0;
        check_eq("pred_idx", 32'(pred_idx), 32'(idx));
        check_eq("prediction", 32'(prediction), 32'(p));
        check_eq("pred_ghr", 32'(pred_ghr), 32'(m_ghr));
        check_eq("ghr_out", 32'(ghr_out), 32'(m_ghr));
`ifdef PHT_DEBUG_EN
        for (int i = 0; i < 8; i++) check_eq("pht_out", 32'(pht_out[i]), 32'(m_ctr[i]));
`endif
        @(posedge clock);
        if (en) begin
            if (uv) begin
                if (ut) m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
                else    m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
            end
            if (uv && um)   m_ghr = ((int'(ug) * 2) + int'(ut)) % 8;
            else if (pv)    m_ghr = ((m_ghr * 2) + p) % 8;
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] pc);
        step(1'b1, 1'b0, pc, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    endtask

    // Reset asserted mid-cycle with updates pending; everything must clear at once.
    task automatic mid_reset();
        enable         = 1'b1;
        pred_valid     = 1'b1;
        pred_pc        = $urandom;
        upd_valid      = 1'b1;
        upd_mispredict = 1'b1;
        upd_taken      = 1'b1;
        upd_idx        = 3'($urandom_range(0, 7));
        upd_ghr        = 3'($urandom_range(0, 7));
        #2 reset = 1'b1;
        #1;
        model_clear();
        check_eq("rst_ghr_out", 32'(ghr_out), 32'd0);
        check_eq("rst_pred_ghr", 32'(pred_ghr), 32'd0);
        check_eq("rst_prediction", 32'(prediction), 32'd0);
        @(posedge clock);
        #1;
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pred_pc = (32'($urandom_range(0, 255)) << 5) | (32'(i) << 2);
            #1;
            check_eq("rst_sweep_pred", 32'(prediction), 32'd0);
            check_eq("rst_sweep_idx", 32'(pred_idx), 32'(i));
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int g_save;
        reset          = 1'b1;
        enable         = 1'b0;
        pred_valid     = 1'b0;
        pred_pc        = 32'h0;
        upd_valid      = 1'b0;
        upd_idx        = 3'd0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
        upd_ghr        = 3'd0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check_eq("reset_ghr_out", 32'(ghr_out), 32'd0);
        check_eq("reset_prediction", 32'(prediction), 32'd0);
        reset = 1'b0;

        // Counter climb at idx 5, prediction flips after the second taken update.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h14, 1'b1, 3'd5, 1'b1, 1'b0, 3'd0);
        idle(32'h14);
        check_eq("req23_sat_hi_pred", 32'(prediction), 32'd1);
        step(1'b1, 1'b0, 32'h14, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 32'h14, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0);
        idle(32'h14);
        check_eq("req23_no_wrap_pred", 32'(prediction), 32'd0);

        // Floor: drive idx 5 below zero, then one taken step must not reach MSB.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h14, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 32'h14, 1'b1, 3'd5, 1'b1, 1'b0, 3'd0);
        idle(32'h14);
        check_eq("req24_floor_pred", 32'(prediction), 32'd0);

        // Saturate every counter, then three speculative shifts of a taken prediction.
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b1, 3'(i), 1'b1, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 32'h14, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        idle(32'h14);
        check_eq("req25_ghr_111", 32'(ghr_out), 32'd7);
        check_eq("req25_idx_2", 32'(pred_idx), 32'd2);

        // Recovery beats a same-cycle speculative shift.
        step(1'b1, 1'b1, 32'h14, 1'b1, 3'd0, 1'b0, 1'b1, 3'b010);
        idle(32'h0);
        check_eq("req26_recover", 32'(ghr_out), 32'd4);

        // Same-index lookup and update: old counter this cycle, new one next.
        step(1'b1, 1'b0, 32'h0, 1'b1, 3'd4, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 3'd4, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 32'(((4 ^ m_ghr) & 7) << 2), 1'b1, 3'd4, 1'b1, 1'b0, 3'd0);
        idle(32'(((4 ^ m_ghr) & 7) << 2));
        check_eq("req27_next_pred", 32'(prediction), 32'd1);

        // Enable low: nothing may move.
        g_save = m_ghr;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'h18, 1'b1, 3'd6, 1'b0, 1'b1, 3'b101);
        idle(32'h18);
        check_eq("req28_hold_ghr", 32'(ghr_out), 32'(g_save));
        mid_reset();
        idle(32'h14);

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                mid_reset();
            end else begin
                step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), $urandom,
                     1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                     3'($urandom_range(0, 7)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
